// File: rtl/led_blink_pkg.sv
// rtl/led_blink_pkg.sv - mode codes, phase timing constants and counter widths for the LED blink engine
package led_blink_pkg;

    localparam int FRAME_W = 12;
    localparam int SUB_W   = 8;

    typedef logic [FRAME_W-1:0] frame_t;
    typedef logic [SUB_W-1:0]   sub_t;

    localparam logic [3:0] LED_OFF   = 4'd0;
    localparam logic [3:0] BLK_1HZ   = 4'd1;
    localparam logic [3:0] BLK_2HZ   = 4'd2;
    localparam logic [3:0] BLK_4HZ   = 4'd3;
    localparam logic [3:0] BURST_05S = 4'd4;
    localparam logic [3:0] BURST_35S = 4'd5;
    localparam logic [3:0] LED_ON    = 4'd6;
    localparam logic [3:0] BLK_07S   = 4'd7;
    localparam logic [3:0] BREATHE   = 4'd8;
    localparam logic [3:0] DIM       = 4'd9;

    // Periods and lit-window lengths, all in 1 ms ticks
    localparam frame_t PER_1HZ      = 12'd1000;
    localparam frame_t ON_1HZ       = 12'd500;
    localparam frame_t PER_2HZ      = 12'd500;
    localparam frame_t ON_2HZ       = 12'd250;
    localparam frame_t PER_4HZ      = 12'd250;
    localparam frame_t ON_4HZ       = 12'd125;
    localparam frame_t PER_07S      = 12'd700;
    localparam frame_t ON_07S       = 12'd350;
    localparam frame_t PER_BURST    = 12'd4000;
    localparam frame_t ON_BURST_05S = 12'd500;
    localparam frame_t ON_BURST_35S = 12'd3500;
    localparam frame_t PER_BREATHE  = 12'd2048;
    localparam frame_t BREATHE_HALF = 12'd1024;
    localparam frame_t PER_IDLE     = 12'd1000;

    localparam sub_t SUB_LAST = 8'd249;
    localparam sub_t SUB_ON   = 8'd125;

    // Steady modes (off/on/dim) have no visible phase; their frame just free-runs.
    function automatic frame_t frame_period(input logic [3:0] code);
        case (code)
            BLK_1HZ:              return PER_1HZ;
            BLK_2HZ:              return PER_2HZ;
            BLK_4HZ:              return PER_4HZ;
            BURST_05S, BURST_35S: return PER_BURST;
            BLK_07S:              return PER_07S;
            BREATHE:              return PER_BREATHE;
            default:              return PER_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/led_blink_engine_if.sv
// rtl/led_blink_engine_if.sv - register-file side mode/control bundle and LED pin drive
interface led_blink_engine_if #(
    parameter int NUM_LED = 16,
    parameter int MODE_W  = 4
);
    logic [NUM_LED*MODE_W-1:0] LED_MODE;
    logic                      GLOBAL_EN;
    logic                      SYNC_REQ;
    logic [NUM_LED-1:0]        LED;

    modport master (output LED_MODE, output GLOBAL_EN, output SYNC_REQ, input LED);
    modport slave  (input LED_MODE, input GLOBAL_EN, input SYNC_REQ, output LED);
endinterface

// File: rtl/led_chan_engine.sv
// rtl/led_chan_engine.sv - one LED channel: registered mode, ms frame/sub phase counters, lit decode
module led_chan_engine
    import led_blink_pkg::*;
#(
    parameter int         MODE_W    = 4,
    parameter logic [7:0] DIM_LEVEL = 8'd64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode_in,
    input  logic              tick,
    input  logic              sync_req,
    input  logic [7:0]        pwm,
    output logic              lit
);

    logic [MODE_W-1:0] mode_q, mode_d;
    frame_t            frame_q, frame_d;
    sub_t              sub_q, sub_d;
    logic              reserved;
    logic [3:0]        code;
    frame_t            period;
    logic [7:0]        bright;

    always_comb begin
        reserved = (mode_q > MODE_W'(DIM));
        code     = reserved ? LED_OFF : mode_q[3:0];
        period   = frame_period(code);
        mode_d   = mode_q;
        frame_d  = frame_q;
        sub_d    = sub_q;

        // A new mode restarts the phase; sync/reserved clears beat a coincident tick.
        if (mode_in != mode_q) begin
            mode_d  = mode_in;
            frame_d = '0;
            sub_d   = '0;
        end else if (sync_req || reserved) begin
            frame_d = '0;
            sub_d   = '0;
        end else if (tick) begin
            if (frame_q == period - FRAME_W'(1)) begin
                frame_d = '0;
                sub_d   = '0;
            end else begin
                frame_d = frame_q + FRAME_W'(1);
                sub_d   = (sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
            end
        end

        bright = (frame_q < BREATHE_HALF) ? frame_q[9:2] : ~frame_q[9:2];

        lit = 1'b0;
        case (code)
            BLK_1HZ:   lit = (frame_q < ON_1HZ);
            BLK_2HZ:   lit = (frame_q < ON_2HZ);
            BLK_4HZ:   lit = (frame_q < ON_4HZ);
            BURST_05S: lit = (frame_q < ON_BURST_05S) && (sub_q < SUB_ON);
            BURST_35S: lit = (frame_q < ON_BURST_35S) && (sub_q < SUB_ON);
            LED_ON:    lit = 1'b1;
            BLK_07S:   lit = (frame_q < ON_07S);
            BREATHE:   lit = (pwm < bright);
            DIM:       lit = (pwm < DIM_LEVEL);
            default:   lit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= '0;
            frame_q <= '0;
            sub_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            frame_q <= frame_d;
            sub_q   <= sub_d;
        end
    end

endmodule

// File: rtl/led_blink_engine.sv
// rtl/led_blink_engine.sv - status LED pattern generator: 1 ms prescaler, PWM counter, channel array, pin register
module led_blink_engine
    import led_blink_pkg::*;
#(
    parameter int         NUM_LED    = 16,
    parameter int         MODE_W     = 4,
    parameter int         TICK_DIV   = 25000,
    parameter bit         ACTIVE_LOW = 1'b0,
    parameter logic [7:0] DIM_LEVEL  = 8'd64
) (
    input logic               SYSCLK,
    input logic               RESET,
    led_blink_engine_if.slave io
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         pwm_q, pwm_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic [NUM_LED-1:0] lit;
    logic               tick;

    always_comb begin
        tick    = (presc_q == PRESC_W'(TICK_DIV - 1));
        presc_d = (io.SYNC_REQ || tick) ? '0 : presc_q + PRESC_W'(1);
        pwm_d   = pwm_q + 8'd1;
        led_d   = ({NUM_LED{io.GLOBAL_EN}} & lit) ^ {NUM_LED{ACTIVE_LOW}};
    end

    for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
        led_chan_engine #(
            .MODE_W    (MODE_W),
            .DIM_LEVEL (DIM_LEVEL)
        ) u_chan (
            .clk      (SYSCLK),
            .rst      (RESET),
            .mode_in  (io.LED_MODE[i*MODE_W +: MODE_W]),
            .tick     (tick),
            .sync_req (io.SYNC_REQ),
            .pwm      (pwm_q),
            .lit      (lit[i])
        );
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            presc_q <= '0;
            pwm_q   <= '0;
            led_q   <= {NUM_LED{ACTIVE_LOW}};
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            led_q   <= led_d;
        end
    end

    assign io.LED = led_q;

endmodule
